// File: rtl/klingon_pkg.sv
// Shared constants for the Klingon-numeral scan display: code width and glyph table.
// Glyphs are active-high, bit0 = segment a through bit6 = segment g.
package klingon_pkg;

    localparam int CODE_W = 4;

    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

    localparam logic [6:0] KLINGON_GLYPH [0:9] = '{
        7'h49, 7'h30, 7'h36, 7'h76, 7'h1D,
        7'h63, 7'h5C, 7'h2B, 7'h7F, 7'h6E
    };

endpackage

// File: rtl/klingon_glyph_rom.sv
// Combinational code-to-glyph lookup; codes above 9 decode to a blank glyph.
// Zero latency, no flow control.
module klingon_glyph_rom
    import klingon_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [6:0]        glyph
);

    always_comb begin
        glyph = GLYPH_BLANK;
        if (code <= CODE_W'(9))
            glyph = KLINGON_GLYPH[code];
    end

endmodule

// File: rtl/klingon_scan_display.sv
// Time-multiplexed N-digit Klingon 7-segment driver with double-buffered value and zero blanking.
// Outputs registered, one cycle behind the scan index; no backpressure, load is a fire-and-forget strobe.
module klingon_scan_display
    import klingon_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic [CODE_W*NUM_DIGITS-1:0] value,
    input  logic                       blank_lz,
    input  logic                       enable,
    output logic [6:0]                 seg,
    output logic [NUM_DIGITS-1:0]      an,
    output logic                       pending,
    output logic                       frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic [6:0]            SEG_OFF = {7{POL}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{POL}};

    logic [CNT_W-1:0]             cnt;
    logic [IDX_W-1:0]             idx;
    logic [CODE_W*NUM_DIGITS-1:0] shadow;
    logic [CODE_W*NUM_DIGITS-1:0] disp;
    logic                         tick;
    logic                         wrap;
    logic [CODE_W-1:0]            code;
    logic [6:0]                   glyph;
    logic [6:0]                   glyph_vis;
    logic [NUM_DIGITS-1:0]        lz;
    logic                         zero_run;
    logic [NUM_DIGITS-1:0]        an_hot;

    assign tick = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign wrap = tick && (idx == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            cnt        <= tick ? '0 : cnt + 1'b1;
            frame_done <= wrap;
            if (wrap)
                idx <= '0;
            else if (tick)
                idx <= idx + 1'b1;
        end
    end

    // A load coinciding with the wrap bypasses the shadow so it lands in this frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow  <= '0;
            disp    <= '0;
            pending <= 1'b0;
        end else if (load) begin
            shadow <= value;
            if (wrap) begin
                disp    <= value;
                pending <= 1'b0;
            end else begin
                pending <= 1'b1;
            end
        end else if (wrap && pending) begin
            disp    <= shadow;
            pending <= 1'b0;
        end
    end

    // lz[k] set when digit k and everything above it is zero; digit 0 always shows.
    always_comb begin
        lz       = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run & (disp[CODE_W*k +: CODE_W] == '0);
            lz[k]    = zero_run;
        end
        lz[0] = 1'b0;
    end

    assign code = disp[CODE_W*int'(idx) +: CODE_W];

    klingon_glyph_rom u_rom (
        .code  (code),
        .glyph (glyph)
    );

    assign glyph_vis = (blank_lz && lz[idx]) ? GLYPH_BLANK : glyph;
    assign an_hot    = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else if (!enable) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= glyph_vis ^ SEG_OFF;
            an  <= an_hot ^ AN_OFF;
        end
    end

endmodule

// File: tb/tb_klingon_scan_display.sv
// Bench for klingon_scan_display: active-low and active-high instances driven in lockstep,
// value table plus hand sequences for wrap-cycle load, double load, enable and mid-frame reset.
module tb_klingon_scan_display;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic        enable;
    logic [6:0]  seg, seg2;
    logic [3:0]  an, an2;
    logic        pending, pending2;
    logic        fd, fd2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    klingon_scan_display #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut (
        .clk(clk), .reset(reset), .load(load), .value(value), .blank_lz(blank_lz),
        .enable(enable), .seg(seg), .an(an), .pending(pending), .frame_done(fd)
    );

    klingon_scan_display #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(0)) dut_ah (
        .clk(clk), .reset(reset), .load(load), .value(value), .blank_lz(blank_lz),
        .enable(enable), .seg(seg2), .an(an2), .pending(pending2), .frame_done(fd2)
    );

    function automatic logic [6:0] gl(input int n);
        case (n)
            0: return 7'h49;
            1: return 7'h30;
            2: return 7'h36;
            3: return 7'h76;
            4: return 7'h1D;
            5: return 7'h63;
            6: return 7'h5C;
            7: return 7'h2B;
            8: return 7'h7F;
            9: return 7'h6E;
            default: return 7'h00;
        endcase
    endfunction

    typedef struct packed {
        logic [1:0] digit;
        logic [6:0] ah;
    } sb_t;

    typedef struct packed {
        logic [15:0]     val;
        logic            blz;
        logic [3:0][6:0] ah;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fd(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            step();
            if (fd === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
        n_cmp++;
        n_err++;
        $display("FAIL frame_done_timeout: no pulse within 40 cycles at %0t", $time);
    endtask

    task automatic wait_an(input logic [1:0] d, output bit ok);
        logic [3:0] want;
        want = ~(4'b0001 << d);
        ok   = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (an === want) begin
                ok = 1'b1;
                return;
            end
            step();
        end
        n_cmp++;
        n_err++;
        $display("FAIL an_timeout: an=%b never reached %b", an, want);
    endtask

    task automatic push_val(input logic [3:0][6:0] ah);
        for (int k = 0; k < 4; k++)
            sb.push_back('{digit: 2'(k), ah: ah[k]});
    endtask

    task automatic do_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    task automatic check_digits;
        sb_t e;
        bit  ok;
        for (int i = 0; i < 4; i++) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard_empty: got 0 entries, expected 4");
                return;
            end
            e = sb.pop_front();
            wait_an(e.digit, ok);
            if (ok) begin
                chk($sformatf("seg_al_d%0d", e.digit), {9'd0, seg}, {9'd0, ~e.ah});
                chk($sformatf("seg_ah_d%0d", e.digit), {9'd0, seg2}, {9'd0, e.ah});
                chk($sformatf("an_ah_d%0d", e.digit), {12'd0, an2}, {12'd0, 4'b0001 << e.digit});
            end
        end
    endtask

    task automatic check_frame;
        bit ok;
        wait_fd(ok);
        if (ok) check_digits();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded 1 ms");
        $fatal(1);
    end

    initial begin
        bit ok;

        vecs[0] = '{16'h1234, 1'b0, {gl(1), gl(2), gl(3), gl(4)}};
        vecs[1] = '{16'h0007, 1'b1, {7'h00, 7'h00, 7'h00, gl(7)}};
        vecs[2] = '{16'h0000, 1'b1, {7'h00, 7'h00, 7'h00, gl(0)}};
        vecs[3] = '{16'h0000, 1'b0, {gl(0), gl(0), gl(0), gl(0)}};
        vecs[4] = '{16'hA5FB, 1'b0, {7'h00, gl(5), 7'h00, 7'h00}};
        vecs[5] = '{16'h0305, 1'b1, {7'h00, gl(3), gl(0), gl(5)}};

        reset    = 1'b1;
        load     = 1'b0;
        value    = 16'h0;
        blank_lz = 1'b0;
        enable   = 1'b1;

        // Reset values while held.
        #22;
        chk("rst_seg_al", {9'd0, seg}, 16'h007F);
        chk("rst_an_al", {12'd0, an}, 16'h000F);
        chk("rst_seg_ah", {9'd0, seg2}, 16'h0000);
        chk("rst_an_ah", {12'd0, an2}, 16'h0000);
        chk("rst_pending", {15'd0, pending}, 16'h0);
        chk("rst_frame_done", {15'd0, fd}, 16'h0);

        @(negedge clk);
        reset = 1'b0;

        // Scan order, slot hold time and frame_done period.
        for (int n = 1; n <= 32; n++) begin
            step();
            if (n <= 20)
                chk($sformatf("scan_an_c%0d", n), {12'd0, an}, {12'd0, ~(4'b0001 << (((n - 1) / 4) % 4))});
            chk($sformatf("fd_c%0d", n), {15'd0, fd}, {15'd0, (n % 16) == 0});
        end

        // Before any load the display shows zeros.
        repeat (5) step();
        chk("pre_load_zero", {9'd0, seg}, {9'd0, ~gl(0)});

        for (int i = 0; i < 6; i++) begin
            blank_lz = vecs[i].blz;
            wait_fd(ok);
            repeat (5) step();
            push_val(vecs[i].ah);
            do_load(vecs[i].val);
            chk($sformatf("v%0d_pending_set", i), {15'd0, pending}, 16'h1);
            if (i == 0)
                chk("v0_old_value_shown", {9'd0, seg}, {9'd0, ~gl(0)});
            check_frame();
            chk($sformatf("v%0d_pending_clr", i), {15'd0, pending}, 16'h0);
        end

        // Load exactly on the wrap edge goes straight to the display.
        blank_lz = 1'b0;
        wait_fd(ok);
        repeat (15) step();
        push_val({gl(9), gl(9), gl(9), gl(9)});
        do_load(16'h9999);
        chk("wrapload_fd", {15'd0, fd}, 16'h1);
        chk("wrapload_pending", {15'd0, pending}, 16'h0);
        check_digits();

        // Two loads in one frame: last value wins.
        wait_fd(ok);
        repeat (3) step();
        do_load(16'h1111);
        repeat (3) step();
        push_val({gl(2), gl(2), gl(2), gl(2)});
        do_load(16'h2222);
        check_frame();

        // Disable mid-scan, frame timing continues, re-enable resumes at current idx.
        wait_fd(ok);
        repeat (5) step();
        enable = 1'b0;
        step();
        chk("dis_seg_al", {9'd0, seg}, 16'h007F);
        chk("dis_an_al", {12'd0, an}, 16'h000F);
        chk("dis_seg_ah", {9'd0, seg2}, 16'h0000);
        chk("dis_an_ah", {12'd0, an2}, 16'h0000);
        wait_fd(ok);
        chk("dis_fd_seen", {15'd0, ok}, 16'h1);
        chk("dis_seg_still_off", {9'd0, seg}, 16'h007F);
        enable = 1'b1;
        step();
        chk("reen_an", {12'd0, an}, 16'h000E);
        chk("reen_seg", {9'd0, seg}, {9'd0, ~gl(2)});

        // Asynchronous reset mid-frame with a pending value.
        wait_fd(ok);
        repeat (3) step();
        do_load(16'h5555);
        chk("mid_pending_set", {15'd0, pending}, 16'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_seg_al", {9'd0, seg}, 16'h007F);
        chk("mid_rst_an_al", {12'd0, an}, 16'h000F);
        chk("mid_rst_seg_ah", {9'd0, seg2}, 16'h0000);
        chk("mid_rst_an_ah", {12'd0, an2}, 16'h0000);
        chk("mid_rst_pending", {15'd0, pending}, 16'h0);
        chk("mid_rst_pending_ah", {15'd0, pending2}, 16'h0);
        chk("mid_rst_fd", {15'd0, fd}, 16'h0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("post_rst_an", {12'd0, an}, 16'h000E);
        chk("post_rst_seg", {9'd0, seg}, {9'd0, ~gl(0)});
        wait_fd(ok);
        step();
        chk("post_rst_shadow_lost", {9'd0, seg}, {9'd0, ~gl(0)});
        chk("post_rst_pending", {15'd0, pending}, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
